// File: rtl/seven_seg_scan_if.sv
// Load-side bus of the seven-segment scanner.
// Carries digit data, decimal points, blanking control and ready.
interface seven_seg_scan_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic                  lz;
   logic                  ready;

   modport master (
      output load,
      output value,
      output dp_in,
      output lz,
      input  ready
   );

   modport slave (
      input  load,
      input  value,
      input  dp_in,
      input  lz,
      output ready
   );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed hex display driver.
// Loads are double-buffered so the display only changes at frame boundaries.
module seven_seg_scan #(
   parameter int DIGITS        = 4,
   parameter int PRESCALE      = 50000,
   parameter bit AN_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   seven_seg_scan_if.slave   bus,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] anode,
   output logic              frame_tick
);

   localparam int PW = $clog2(PRESCALE);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIGITS-1:0] AN_OFF =
      AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [PW-1:0]         psc;
   logic [IW-1:0]         idx;
   logic                  tc;
   logic                  wrap;
   logic [4*DIGITS-1:0]   shadow;
   logic [4*DIGITS-1:0]   disp;
   logic [DIGITS-1:0]     sdp;
   logic [DIGITS-1:0]     ddp;
   logic                  pending;

   logic [3:0]            nib;
   logic                  cur_dp;
   logic                  nz_sel;
   logic                  acc;
   logic                  blank;
   logic [DIGITS-1:0]     onehot;
   logic [6:0]            seg_d;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tc         = (psc == PW'(PRESCALE - 1));
   assign wrap       = tc && (idx == IW'(DIGITS - 1));
   assign frame_tick = wrap;
   assign bus.ready  = ~pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc <= '0;
         idx <= '0;
      end else if (tc) begin
         psc <= '0;
         idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         psc <= psc + 1'b1;
      end
   end

   // A load on the swap cycle lands in the shadow after the old one moves out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow  <= '0;
         sdp     <= '0;
         disp    <= '0;
         ddp     <= '0;
         pending <= 1'b0;
      end else begin
         if (bus.load) begin
            shadow <= bus.value;
            sdp    <= bus.dp_in;
         end
         if (wrap && pending) begin
            disp <= shadow;
            ddp  <= sdp;
         end
         pending <= bus.load | (pending & ~wrap);
      end
   end

   // Walk from the top digit down so each digit knows if anything above it is lit.
   always_comb begin
      nib    = '0;
      cur_dp = 1'b0;
      nz_sel = 1'b0;
      acc    = 1'b0;
      onehot = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         acc       = acc | (|disp[4*k +: 4]);
         onehot[k] = (idx == IW'(k));
         if (idx == IW'(k)) begin
            nib    = disp[4*k +: 4];
            cur_dp = ddp[k];
            nz_sel = acc;
         end
      end
   end

   assign blank = bus.lz && (idx != '0) && !nz_sel;
   assign seg_d = blank ? 7'h7F : hex7(nib);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg   <= 7'h7F;
         dp    <= 1'b1;
         anode <= AN_OFF;
      end else begin
         seg   <= seg_d;
         dp    <= ~cur_dp;
         anode <= AN_ACTIVE_LOW ? ~onehot : onehot;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan, DIGITS=4, PRESCALE=4.
// Digit d of a frame is sampled 2+4d negedges after frame_tick.
module tb_seven_seg_scan;

   localparam int D = 4;
   localparam int P = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [6:0]   seg;
   logic         dp;
   logic [D-1:0] anode;
   logic         frame_tick;
   int           total = 0;
   int           bad = 0;

   seven_seg_scan_if #(.DIGITS(D)) bus ();

   seven_seg_scan #(
      .DIGITS(D),
      .PRESCALE(P),
      .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .seg(seg),
      .dp(dp),
      .anode(anode),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ft(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 100);
      chk({tag, "_ft"}, {31'b0, frame_tick}, 32'd1);
   endtask

   task automatic ld(input logic [15:0] v, input logic [3:0] p);
      bus.value = v;
      bus.dp_in = p;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
   endtask

   task automatic frame(input string tag, input logic [27:0] es,
                        input logic [3:0] edp);
      logic [3:0] oh;
      wait_ft(tag);
      repeat (2) @(negedge clk);
      for (int d = 0; d < D; d++) begin
         oh = 4'b0001 << d;
         chk($sformatf("%s_seg%0d", tag, d), {25'b0, seg}, {25'b0, es[7*d +: 7]});
         chk($sformatf("%s_an%0d", tag, d), {28'b0, anode}, {28'b0, ~oh});
         chk($sformatf("%s_dp%0d", tag, d), {31'b0, dp}, {31'b0, ~edp[d]});
         if (d < D - 1) repeat (4) @(negedge clk);
      end
   endtask

   initial begin
      logic [3:0] oh;
      bus.load  = 1'b0;
      bus.value = '0;
      bus.dp_in = '0;
      bus.lz    = 1'b0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_seg", {25'b0, seg}, 32'h7F);
      chk("rst_dp", {31'b0, dp}, 32'd1);
      chk("rst_an", {28'b0, anode}, 32'hF);
      chk("rst_ft", {31'b0, frame_tick}, 32'd0);
      chk("rst_rdy", {31'b0, bus.ready}, 32'd1);
      reset = 1'b0;

      // free-run anode walk and frame_tick period
      for (int n = 1; n <= 32; n++) begin
         @(negedge clk);
         oh = 4'b0001 << (((n - 1) / 4) % 4);
         chk($sformatf("walk_an%0d", n), {28'b0, anode}, {28'b0, ~oh});
         chk($sformatf("walk_ft%0d", n), {31'b0, frame_tick},
             (n % 16 == 15) ? 32'd1 : 32'd0);
         chk($sformatf("walk_seg%0d", n), {25'b0, seg}, 32'h40);
      end

      // basic load with decimal points
      ld(16'h12AF, 4'b0101);
      chk("ld_rdy0", {31'b0, bus.ready}, 32'd0);
      frame("hexA", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0101);
      chk("ld_rdy1", {31'b0, bus.ready}, 32'd1);

      // two loads in one frame, last wins
      wait_ft("two");
      repeat (3) @(negedge clk);
      ld(16'h1111, 4'b0000);
      chk("two_rdy_a", {31'b0, bus.ready}, 32'd0);
      ld(16'h2222, 4'b0000);
      chk("two_rdy_b", {31'b0, bus.ready}, 32'd0);
      frame("two", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000);

      // leading-zero suppression
      bus.lz = 1'b1;
      wait_ft("lz1");
      repeat (2) @(negedge clk);
      ld(16'h0050, 4'b0000);
      frame("lz1", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0000);
      wait_ft("lz0");
      repeat (2) @(negedge clk);
      ld(16'h0000, 4'b1000);
      frame("lz0", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1000);
      bus.lz = 1'b0;

      // load coinciding with the swap
      wait_ft("coin");
      repeat (2) @(negedge clk);
      ld(16'h3333, 4'b0000);
      wait_ft("coin_a");
      chk("coin_rdy_a", {31'b0, bus.ready}, 32'd0);
      bus.value = 16'h4444;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load  = 1'b0;
      chk("coin_rdy_b", {31'b0, bus.ready}, 32'd0);
      @(negedge clk);
      chk("coin_old", {25'b0, seg}, 32'h30);
      chk("coin_an", {28'b0, anode}, 32'hE);
      repeat (10) @(negedge clk);
      chk("coin_rdy_c", {31'b0, bus.ready}, 32'd0);
      frame("coin", {7'h19, 7'h19, 7'h19, 7'h19}, 4'b0000);
      chk("coin_rdy_d", {31'b0, bus.ready}, 32'd1);

      // async reset mid-digit with pending data
      wait_ft("ar");
      repeat (5) @(negedge clk);
      ld(16'h5555, 4'b1111);
      chk("ar_rdy0", {31'b0, bus.ready}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("ar_seg", {25'b0, seg}, 32'h7F);
      chk("ar_an", {28'b0, anode}, 32'hF);
      chk("ar_dp", {31'b0, dp}, 32'd1);
      chk("ar_ft", {31'b0, frame_tick}, 32'd0);
      chk("ar_rdy", {31'b0, bus.ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      frame("ar", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
      chk("ar_rdy1", {31'b0, bus.ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
